// File: rtl/acia_pkg.sv
// Shared ACIA definitions: frame constants, FSM states and baud helper.
// Used by both the receive and transmit paths.
package acia_pkg;

  localparam int   ACIA_FRAME_BITS = 10;
  localparam logic ACIA_IDLE       = 1'b1;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_e;

  function automatic int sym_cnt(
    input int clk_freq,
    input int sym_rate
  );
    return clk_freq / sym_rate;
  endfunction

endpackage

// File: rtl/acia_tx_if.sv
// CPU-side write bus of the ACIA transmitter.
// master = bus logic, slave = transmitter.
interface acia_tx_if;

  logic [7:0] tx_dat;
  logic       tx_start;
  logic       tx_full;
  logic       tx_busy;

  modport master (
    output tx_dat,
    output tx_start,
    input  tx_full,
    input  tx_busy
  );

  modport slave (
    input  tx_dat,
    input  tx_start,
    output tx_full,
    output tx_busy
  );

endinterface

// File: rtl/acia_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// Pointers carry one extra wrap bit to tell full from empty.
module acia_tx_fifo
  import acia_pkg::*;
#(
  parameter int depth = 4,
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW:0]      wp_q;
  logic [AW:0]      rp_q;
  logic             do_wr;
  logic             do_rd;

  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = (wp_q == rp_q);
  assign dout  = mem[rp_q[AW-1:0]];

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/acia_tx.sv
// ACIA transmitter: byte FIFO feeding an 8N1 shifter.
// Bit timing advances only on pclk-enabled cycles.
module acia_tx
  import acia_pkg::*;
#(
  parameter int clk_freq   = 4000000,
  parameter int sym_rate   = 9600,
  parameter int fifo_depth = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pclk,
  acia_tx_if.slave   bus,
  output logic       tx_serial
);

  localparam int SYM = sym_cnt(clk_freq, sym_rate);
  localparam int SCW = (SYM > 1) ? $clog2(SYM) : 1;
  localparam logic [SCW-1:0] RLOAD = SCW'(SYM - 1);
  localparam logic [3:0]     BLOAD = 4'(ACIA_FRAME_BITS - 1);

  tx_state_e      state_q, state_n;
  logic [9:0]     sreg_q, sreg_n;
  logic [3:0]     bcnt_q, bcnt_n;
  logic [SCW-1:0] rcnt_q, rcnt_n;
  logic           ser_q, ser_n;
  logic           busy_q, busy_n;

  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [7:0] head;

  assign push = bus.tx_start && !full;

  acia_tx_fifo #(
    .depth (fifo_depth),
    .width (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .rd    (pop),
    .din   (bus.tx_dat),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state_q;
    sreg_n  = sreg_q;
    bcnt_n  = bcnt_q;
    rcnt_n  = rcnt_q;
    pop     = 1'b0;
    if (pclk) begin
      unique case (state_q)
        TX_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            sreg_n  = {ACIA_IDLE, head, 1'b0};
            bcnt_n  = BLOAD;
            rcnt_n  = RLOAD;
            state_n = TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (rcnt_q != '0) begin
            rcnt_n = rcnt_q - 1'b1;
          end else if (bcnt_q != '0) begin
            sreg_n = {ACIA_IDLE, sreg_q[9:1]};
            bcnt_n = bcnt_q - 1'b1;
            rcnt_n = RLOAD;
          end else if (!empty) begin
            // stop bit done: chain the next frame with no idle gap
            pop    = 1'b1;
            sreg_n = {ACIA_IDLE, head, 1'b0};
            bcnt_n = BLOAD;
            rcnt_n = RLOAD;
          end else begin
            state_n = TX_IDLE;
          end
        end
        default: state_n = TX_IDLE;
      endcase
    end
  end

  // a pop always lands in SHIFT, so non-empty-after is push | !empty
  assign ser_n  = (state_n == TX_SHIFT) ? sreg_n[0] : ACIA_IDLE;
  assign busy_n = (state_n == TX_SHIFT) || push || !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      sreg_q  <= '1;
      bcnt_q  <= '0;
      rcnt_q  <= '0;
      ser_q   <= ACIA_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sreg_q  <= sreg_n;
      bcnt_q  <= bcnt_n;
      rcnt_q  <= rcnt_n;
      ser_q   <= ser_n;
      busy_q  <= busy_n;
    end
  end

  assign tx_serial   = ser_q;
  assign bus.tx_full = full;
  assign bus.tx_busy = busy_q;

endmodule
